// File: rtl/memref_responder.sv
// Memory-side responder for the HIR memref read/write port protocol.
// One read port (p0), one write port (p1), a backdoor load port, a
// read pipeline of RD_LATENCY stages, and sticky access/error monitoring.
module memref_responder #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] p0_addr_data,
  input  logic                  p0_addr_en,
  input  logic                  p0_rd_en,
  output logic [WIDTH-1:0]      p0_rd_data,
  output logic                  p0_rd_valid,
  input  logic [ADDR_WIDTH-1:0] p1_addr_data,
  input  logic                  p1_addr_en,
  input  logic                  p1_wr_en,
  input  logic [WIDTH-1:0]      p1_wr_data,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_data,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic                  err_proto,
  output logic                  err_oob,
  output logic                  err_coll
);

  typedef logic [WIDTH-1:0] word_t;

  word_t                 mem [SIZE];
  logic                  rd_acc;
  logic                  rd_in_range;
  logic                  p1_req;
  logic                  p1_in_range;
  logic                  p1_commit;
  logic                  ld_in_range;
  logic                  ld_eff;
  word_t                 rd_word;
  logic [RD_LATENCY-1:0] pv;
  word_t                 pd [RD_LATENCY];

  // Decode port requests and form the word captured by an accepted read
  always_comb begin
    rd_acc      = p0_rd_en & p0_addr_en;
    rd_in_range = 32'(p0_addr_data) < SIZE;
    p1_req      = p1_wr_en & p1_addr_en;
    p1_in_range = 32'(p1_addr_data) < SIZE;
    p1_commit   = p1_req & p1_in_range;
    ld_in_range = 32'(ld_addr) < SIZE;
    // A committed p1 write always pre-empts a backdoor load in the same cycle
    ld_eff      = ld_en & ~p1_commit & ld_in_range;
    rd_word     = '0;
    if (rd_in_range) begin
      rd_word = mem[p0_addr_data];
      if (RDW_MODE != 0) begin
        if (p1_commit && (p1_addr_data == p0_addr_data)) begin
          rd_word = p1_wr_data;
        end else if (ld_eff && (ld_addr == p0_addr_data)) begin
          rd_word = ld_data;
        end
      end
    end
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (p1_commit) begin
      mem[p1_addr_data] <= p1_wr_data;
    end else if (ld_eff) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Read pipeline: data stages only advance with a valid entry, so the last
  // stage doubles as the hold register for p0_rd_data between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv <= (pv << 1) | RD_LATENCY'(rd_acc);
      if (rd_acc) begin
        pd[0] <= rd_word;
      end
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  assign p0_rd_valid = pv[RD_LATENCY-1];
  assign p0_rd_data  = pd[RD_LATENCY-1];

  // Saturating access counters and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_proto <= 1'b0;
      err_oob   <= 1'b0;
      err_coll  <= 1'b0;
    end else begin
      if (rd_acc && (rd_count != '1)) begin
        rd_count <= rd_count + 32'd1;
      end
      if (p1_commit && (wr_count != '1)) begin
        wr_count <= wr_count + 32'd1;
      end
      if ((p0_rd_en && !p0_addr_en) || (p1_wr_en && !p1_addr_en)) begin
        err_proto <= 1'b1;
      end
      if ((rd_acc && !rd_in_range) || (p1_req && !p1_in_range) ||
          (ld_en && !ld_in_range)) begin
        err_oob <= 1'b1;
      end
      if (ld_en && p1_commit) begin
        err_coll <= 1'b1;
      end
    end
  end

endmodule

// File: doc/memref_responder.md
Name: memref_responder

Overview:
Synthesizable responder for the HIR memref port protocol. It is the memory side of the addr/rd_en/rd_data and addr/wr_en/wr_data handshakes that generated kernels drive as initiators.
One read port (p0) and one write port (p1) front a SIZE-entry array. There is a configurable read latency, a defined read-during-write policy, and access/error monitoring.
It replaces behavioural memref_rd/memref_wr pairs so that kernel-plus-memory can be synthesized and checked on FPGA. A backdoor load port lets a bench preload contents.

Parameters:
WIDTH, 32, data width in bits
SIZE, 1024, number of entries
ADDR_WIDTH, 10, address width; must satisfy 2^ADDR_WIDTH >= SIZE
RD_LATENCY, 1, cycles from accepted read to rd_data; legal range 1..4
RDW_MODE, 0, same-address read/write in one cycle: 0 = return old data, 1 = return new (write-first)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
p0_addr_data  in  ADDR_WIDTH  read address
p0_addr_en  in  1  read address qualifier
p0_rd_en  in  1  read request
p0_rd_data  out  WIDTH  read data
p0_rd_valid  out  1  one-cycle pulse marking p0_rd_data valid
p1_addr_data  in  ADDR_WIDTH  write address
p1_addr_en  in  1  write address qualifier
p1_wr_en  in  1  write request
p1_wr_data  in  WIDTH  write data
ld_en  in  1  backdoor load strobe
ld_addr  in  ADDR_WIDTH  backdoor load address
ld_data  in  WIDTH  backdoor load data
rd_count  out  32  accepted reads, saturating
wr_count  out  32  committed p1 writes, saturating
err_proto  out  1  sticky protocol error
err_oob  out  1  sticky out-of-range error
err_coll  out  1  sticky ld/p1 collision

Behaviour:
- Reset (rst=1, asynchronous):
  - p0_rd_data=0, p0_rd_valid=0, all pipeline valid bits cleared.
  - rd_count=0, wr_count=0, all err_* = 0.
  - Array contents are not cleared; in-flight reads are discarded (no valid pulse after rst deasserts).
- Read acceptance:
  - Read accepted on a rising edge with p0_rd_en=1 and p0_addr_en=1.
  - p0_rd_en=1 with p0_addr_en=0: no access, no valid pulse, err_proto set.
- Read latency:
  - A read accepted at edge T drives p0_rd_valid=1 for exactly one cycle after edge T+RD_LATENCY-1, carrying mem[addr] as sampled at edge T.
  - With RD_LATENCY=1, data is visible the cycle after the request.
  - p0_rd_data holds its last value when p0_rd_valid=0.
  - Back-to-back reads every cycle: full throughput, one result per cycle, order preserved.
- Write:
  - Committed at a rising edge with p1_wr_en=1 and p1_addr_en=1.
  - p1_wr_en=1 with p1_addr_en=0: dropped, err_proto set.
- Read-during-write, same edge, same in-range address:
  - RDW_MODE=0 returns the pre-write value.
  - RDW_MODE=1 returns p1_wr_data.
  - Different addresses do not interact.
- Out of range (address >= SIZE):
  - Read: still returns a valid pulse with data 0, sets err_oob, counted in rd_count.
  - Write: dropped, sets err_oob, not counted.
  - ld_en with ld_addr >= SIZE: dropped, sets err_oob.
- Backdoor load:
  - ld_en=1 writes ld_data to ld_addr at the edge; not counted in wr_count.
  - ld_en and a committed p1 write in the same cycle: the p1 write wins, the load is dropped, err_coll set (regardless of addresses).
  - A load has the same read-during-write interaction with p0 as a p1 write.
- Counters: increment by 1 per event and saturate at 32'hFFFFFFFF; no wrap.
- Error flags: sticky, cleared only by rst.

Test Plan:
- Preload mem[5]=32'h3F800000 via ld, RD_LATENCY=1; read addr 5 at edge T -> p0_rd_valid=1 for one cycle after edge T with data 32'h3F800000; rd_count=1.
- RD_LATENCY=3, reads of addrs 0,1,2,3 on consecutive cycles with mem[i]=i+10 -> valid pulses on 4 consecutive cycles carrying 10,11,12,13, the first valid following the third edge after the first request.
- mem[7]=1; same edge: write 7 <= 9 and read 7 -> RDW_MODE=0 returns 1, RDW_MODE=1 returns 9; a following read of 7 returns 9 in both modes; wr_count=1.
- Read addr 1023 with SIZE=1000 -> valid pulse with data 0, err_oob=1; write to 1000 -> mem unchanged, wr_count unchanged.
- ld_en (addr 3, data 4) together with p1 write (addr 3, data 8) -> mem[3]=8, err_coll=1; p0_rd_en=1 with p0_addr_en=0 -> no valid pulse, err_proto=1.
- Assert rst with two reads in flight (RD_LATENCY=2) -> no valid pulses after release, counters and flags 0, previously loaded mem contents still readable.
